// File: rtl/pond_port_arbiter_if.sv
// Accessor and pond-memory signals shared by the port arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the accessor/memory side.
interface pond_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) ();
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_pending;
  logic [15:0]           conflict_count;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    output wr_ack, rd_ack, rd_data, rd_data_valid, mem_wen, mem_addr, mem_wdata,
    output wr_pending, conflict_count
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    input  wr_ack, rd_ack, rd_data, rd_data_valid, mem_wen, mem_addr, mem_wdata,
    input  wr_pending, conflict_count
  );
endinterface

// File: rtl/pond_port_arbiter.sv
// Single-port pond arbiter: one memory op per cycle, 1-entry write skid register,
// pending-write forwarding to reads, round-robin or read-priority contention.
module pond_port_arbiter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned READ_PRIORITY = 0
) (
  input logic                 clk,
  input logic                 rst,
  pond_port_arbiter_if.slave  bus
);

  localparam logic [0:0] RrRead  = 1'b0;
  localparam logic [0:0] RrWrite = 1'b1;

  logic                  pend_v_q, pend_v_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [0:0]            rr_last_q, rr_last_d;

  logic ws, rs, contend, read_wins, grant_rd, grant_wr, wr_ack, load_new, fwd_hit;

  always_comb begin
    ws        = pend_v_q | bus.wr_req;
    rs        = bus.rd_req;
    contend   = ~rst & ws & rs;
    read_wins = (READ_PRIORITY != 0) || (rr_last_q == RrWrite);
    grant_rd  = ~rst & rs & (~ws | read_wins);
    grant_wr  = ~rst & ws & ~grant_rd;
    // An accepted write that is not issued directly lands in the skid register.
    wr_ack    = ~rst & bus.wr_req & (~pend_v_q | grant_wr);
    load_new  = wr_ack & (pend_v_q | ~grant_wr);
    fwd_hit   = pend_v_q & (pend_addr_q == bus.rd_addr);

    pend_v_d    = load_new | (pend_v_q & ~grant_wr);
    pend_addr_d = load_new ? bus.wr_addr : pend_addr_q;
    pend_data_d = load_new ? bus.wr_data : pend_data_q;

    rd_valid_d = grant_rd;
    rd_data_d  = rd_data_q;
    if (grant_rd) rd_data_d = fwd_hit ? pend_data_q : bus.mem_rdata;

    cnt_d = cnt_q;
    if (contend && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;

    rr_last_d = rr_last_q;
    if (contend) rr_last_d = grant_wr ? RrWrite : RrRead;
  end

  always_comb begin
    bus.mem_wen   = grant_wr;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_wr) begin
      bus.mem_addr  = pend_v_q ? pend_addr_q : bus.wr_addr;
      bus.mem_wdata = pend_v_q ? pend_data_q : bus.wr_data;
    end else if (grant_rd) begin
      bus.mem_addr  = bus.rd_addr;
    end
  end

  assign bus.wr_ack         = wr_ack;
  assign bus.rd_ack         = grant_rd;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_data_valid  = rd_valid_q;
  assign bus.wr_pending     = pend_v_q;
  assign bus.conflict_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      cnt_q       <= '0;
      rr_last_q   <= RrWrite;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_pond_port_arbiter.sv
// Directed bench for pond_port_arbiter: a round-robin instance and a read-priority
// instance, each backed by a small behavioural pond memory.
module tb_pond_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pond_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus0 ();
  pond_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus1 ();

  pond_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .READ_PRIORITY(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pond_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .READ_PRIORITY(1)) u_rp (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [15:0] mem0 [32];
  logic [15:0] mem1 [32];

  assign bus0.mem_rdata = mem0[bus0.mem_addr];
  assign bus1.mem_rdata = mem1[bus1.mem_addr];

  always @(posedge clk) begin
    if (bus0.mem_wen) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    if (bus1.mem_wen) mem1[bus1.mem_addr] <= bus1.mem_wdata;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic wq, input logic [4:0] wa, input logic [15:0] wd,
                        input logic rq, input logic [4:0] ra);
    bus0.wr_req = wq; bus0.wr_addr = wa; bus0.wr_data = wd;
    bus0.rd_req = rq; bus0.rd_addr = ra;
    #1;
  endtask

  task automatic drive1(input logic wq, input logic [4:0] wa, input logic [15:0] wd,
                        input logic rq, input logic [4:0] ra);
    bus1.wr_req = wq; bus1.wr_addr = wa; bus1.wr_data = wd;
    bus1.rd_req = rq; bus1.rd_addr = ra;
    #1;
  endtask

  initial begin
    drive1(1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    #1;
    // Outputs stay quiet while reset is held, even with both requests up.
    drive0(1'b1, 5'd3, 16'h00AA, 1'b1, 5'd4);
    check_value("rst_mem_wen", 32'(bus0.mem_wen), 32'd0);
    check_value("rst_wr_ack", 32'(bus0.wr_ack), 32'd0);
    check_value("rst_rd_ack", 32'(bus0.rd_ack), 32'd0);
    check_value("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check_value("rst_pending", 32'(bus0.wr_pending), 32'd0);
    check_value("rst_count", 32'(bus0.conflict_count), 32'd0);
    check_value("rst_rd_valid", 32'(bus0.rd_data_valid), 32'd0);

    // Write-only: direct issue.
    drive0(1'b1, 5'd3, 16'h00AA, 1'b0, 5'd0);
    check_value("wo_mem_wen", 32'(bus0.mem_wen), 32'd1);
    check_value("wo_mem_addr", 32'(bus0.mem_addr), 32'd3);
    check_value("wo_mem_wdata", 32'(bus0.mem_wdata), 32'h00AA);
    check_value("wo_wr_ack", 32'(bus0.wr_ack), 32'd1);
    tick();
    check_value("wo_pending", 32'(bus0.wr_pending), 32'd0);

    // Preload mem[7] through the arbiter, then read it back.
    drive0(1'b1, 5'd7, 16'h1234, 1'b0, 5'd0);
    tick();
    drive0(1'b0, 5'd0, 16'h0, 1'b1, 5'd7);
    check_value("ro_rd_ack", 32'(bus0.rd_ack), 32'd1);
    check_value("ro_mem_wen", 32'(bus0.mem_wen), 32'd0);
    check_value("ro_mem_addr", 32'(bus0.mem_addr), 32'd7);
    tick();
    check_value("ro_rd_data", 32'(bus0.rd_data), 32'h1234);
    check_value("ro_rd_valid", 32'(bus0.rd_data_valid), 32'd1);

    // First contention goes to the read; the write is buffered.
    drive0(1'b1, 5'd5, 16'h0055, 1'b1, 5'd9);
    check_value("c1_rd_ack", 32'(bus0.rd_ack), 32'd1);
    check_value("c1_wr_ack", 32'(bus0.wr_ack), 32'd1);
    check_value("c1_mem_wen", 32'(bus0.mem_wen), 32'd0);
    check_value("c1_mem_addr", 32'(bus0.mem_addr), 32'd9);
    tick();
    check_value("c1_pending", 32'(bus0.wr_pending), 32'd1);
    check_value("c1_count", 32'(bus0.conflict_count), 32'd1);

    // Second contention goes to the write side: pending (5,0x55) issues, (5,0x77) buffered.
    drive0(1'b1, 5'd5, 16'h0077, 1'b1, 5'd5);
    check_value("c2_mem_wen", 32'(bus0.mem_wen), 32'd1);
    check_value("c2_mem_addr", 32'(bus0.mem_addr), 32'd5);
    check_value("c2_mem_wdata", 32'(bus0.mem_wdata), 32'h0055);
    check_value("c2_wr_ack", 32'(bus0.wr_ack), 32'd1);
    check_value("c2_rd_ack", 32'(bus0.rd_ack), 32'd0);
    tick();
    check_value("c2_count", 32'(bus0.conflict_count), 32'd2);
    check_value("c2_pending", 32'(bus0.wr_pending), 32'd1);
    check_value("c2_rd_valid", 32'(bus0.rd_data_valid), 32'd0);

    // Read wins against the pending (5,0x77): forwarded over stale memory 0x55.
    drive0(1'b0, 5'd0, 16'h0, 1'b1, 5'd5);
    check_value("fw_rd_ack", 32'(bus0.rd_ack), 32'd1);
    check_value("fw_mem_wen", 32'(bus0.mem_wen), 32'd0);
    check_value("fw_stale_mem", 32'(bus0.mem_rdata), 32'h0055);
    tick();
    check_value("fw_rd_data", 32'(bus0.rd_data), 32'h0077);
    check_value("fw_rd_valid", 32'(bus0.rd_data_valid), 32'd1);
    check_value("fw_count", 32'(bus0.conflict_count), 32'd3);
    check_value("fw_pending", 32'(bus0.wr_pending), 32'd1);

    // Reset mid-operation drops the pending write.
    drive0(1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    rst = 1'b1;
    #1;
    check_value("mr_mem_wen", 32'(bus0.mem_wen), 32'd0);
    tick();
    rst = 1'b0;
    check_value("mr_pending", 32'(bus0.wr_pending), 32'd0);
    check_value("mr_count", 32'(bus0.conflict_count), 32'd0);
    check_value("mr_rd_valid", 32'(bus0.rd_data_valid), 32'd0);
    #1;
    check_value("mr_no_issue", 32'(bus0.mem_wen), 32'd0);
    tick();
    drive0(1'b0, 5'd0, 16'h0, 1'b1, 5'd5);
    tick();
    check_value("mr_mem5", 32'(bus0.rd_data), 32'h0055);
    drive0(1'b0, 5'd0, 16'h0, 1'b0, 5'd0);

    // Read-priority back-pressure.
    drive1(1'b1, 5'd1, 16'h0011, 1'b1, 5'd0);
    check_value("bp1_rd_ack", 32'(bus1.rd_ack), 32'd1);
    check_value("bp1_wr_ack", 32'(bus1.wr_ack), 32'd1);
    check_value("bp1_mem_wen", 32'(bus1.mem_wen), 32'd0);
    tick();
    check_value("bp1_pending", 32'(bus1.wr_pending), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      drive1(1'b1, 5'd2, 16'h0022, 1'b1, 5'd0);
      check_value($sformatf("bp%0d_wr_ack", i), 32'(bus1.wr_ack), 32'd0);
      check_value($sformatf("bp%0d_rd_ack", i), 32'(bus1.rd_ack), 32'd1);
      tick();
    end
    check_value("bp_count", 32'(bus1.conflict_count), 32'd4);
    drive1(1'b1, 5'd2, 16'h0022, 1'b0, 5'd0);
    check_value("bp5_mem_wen", 32'(bus1.mem_wen), 32'd1);
    check_value("bp5_mem_addr", 32'(bus1.mem_addr), 32'd1);
    check_value("bp5_mem_wdata", 32'(bus1.mem_wdata), 32'h0011);
    check_value("bp5_wr_ack", 32'(bus1.wr_ack), 32'd1);
    tick();
    check_value("bp5_pending", 32'(bus1.wr_pending), 32'd1);
    drive1(1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    check_value("bp6_mem_wen", 32'(bus1.mem_wen), 32'd1);
    check_value("bp6_mem_addr", 32'(bus1.mem_addr), 32'd2);
    check_value("bp6_mem_wdata", 32'(bus1.mem_wdata), 32'h0022);
    check_value("bp6_wr_ack", 32'(bus1.wr_ack), 32'd0);
    tick();
    check_value("bp6_pending", 32'(bus1.wr_pending), 32'd0);
    check_value("bp6_count", 32'(bus1.conflict_count), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pond_port_arbiter.md
Name: pond_port_arbiter

Overview:
- Shares the single-ported pond storage between the write-side accessor (input2pond) and the read-side accessor (pond2output). Both accessors are driven by their own for-loop, address and schedule generators.
- Grants at most one memory operation per cycle.
- Absorbs one losing write in a 1-entry skid register.
- Forwards pending-write data to colliding reads.
- Returns stall (ack) feedback so each accessor's step is taken only on grant.

Parameters:
- DATA_WIDTH, 16, pond word width
- ADDR_WIDTH, 5, pond address width (32 words)
- READ_PRIORITY, 0, 0 = round-robin between read and write sides; 1 = read always wins

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_req  in  1  write accessor valid (sched_gen valid_output)
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_ack  out  1  write accepted this cycle; accessor steps only when high
- rd_req  in  1  read accessor valid
- rd_addr  in  ADDR_WIDTH  read address
- rd_ack  out  1  read granted this cycle; accessor steps only when high
- rd_data  out  DATA_WIDTH  registered read data
- rd_data_valid  out  1  rd_data valid, one cycle after rd_ack
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address (read or write)
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  combinational memory read data for mem_addr
- wr_pending  out  1  skid register occupied
- conflict_count  out  16  saturating count of contended cycles

Behaviour:
- Reset (sync, rst=1 at posedge) clears the following: pend_v, pend_addr, pend_data, rd_data, rd_data_valid, conflict_count, and rr_last (set to write-won, so the first contention goes to read).
- Combinational outputs are 0 while rst is held.
- Reset mid-operation drops any pending write; it is never written.
- Write-side candidate WS = pending entry if pend_v, else the incoming write if wr_req. Read candidate RS = rd_req.
- Contention = WS & RS. Winner:
  - READ_PRIORITY=1: read always wins.
  - READ_PRIORITY=0: the side opposite rr_last wins.
  - rr_last updates only on contended cycles.
- Uncontended: the single candidate is granted.
- Grant read: mem_wen=0, mem_addr=rd_addr, rd_ack=1. Next cycle rd_data_valid=1 and rd_data = pend_data if pend_v & pend_addr==rd_addr (forward), else mem_rdata.
- Grant write: mem_wen=1 with addr/data taken from the pending entry if pend_v, else from wr_addr/wr_data.
- wr_ack rules (combinational):
  - Case 1: pend_v=0 and wr_req. Then wr_ack=1. The write is issued directly if it wins; otherwise it is loaded into the pending entry (pend_v<=1).
  - Case 2: pend_v=1, pending issued this cycle, wr_req. Then wr_ack=1 and the new write is loaded into the pending entry.
  - Case 3: pend_v=1, pending not issued. Then wr_ack=0 and the requester holds.
- pend_v clears when the pending entry issues and no new write is loaded.
- Write order is preserved: the pending entry always issues before any newer write.
- A write accepted in a cycle is not visible to a read granted in the same cycle (read-before-write). It is visible to all later reads via forwarding or memory.
- No read buffering: rd_ack=0 means the read did not occur; the requester holds rd_addr.
- conflict_count increments on every contended cycle and saturates at 16'hFFFF.
- Round-robin guarantees that neither side waits more than 1 contended cycle. With READ_PRIORITY=1, continuous reads may stall writes indefinitely (allowed).
- Width: addresses are compared in full ADDR_WIDTH; no wrap arithmetic inside the block.

Test Plan:
- Write-only: wr_req with addr 3/data 0x00AA, no reads. Expect mem_wen=1, mem_addr=3, wr_ack=1 same cycle, wr_pending stays 0.
- Read-only after preload (mem[7]=0x1234): rd_req addr 7. Expect rd_ack=1, then next cycle rd_data=0x1234, rd_data_valid=1.
- First contention, round-robin: wr(5,0x0055) and rd(9) in the same cycle. Expect read granted, wr_ack=1, wr_pending=1. Next cycle the pending write issues (mem_addr=5). conflict_count=1.
- Forwarding: pending write (5,0x0055) and a read of addr 5 that wins. Expect rd_data=0x0055 next cycle, not stale memory.
- Back-pressure, READ_PRIORITY=1: rd_req held 4 cycles, wr_req held with addr 1,2. Expect the first write buffered, then wr_ack=0 for cycles 2-4, conflict_count=4. After rd_req drops, writes 1 then 2 issue in order.
- Reset mid-op: assert rst with wr_pending=1 and conflict_count=3. Expect next cycle wr_pending=0, conflict_count=0, rd_data_valid=0, and no mem_wen for the dropped entry.
